// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and sizing helpers for the FIFO stream reader and its output buffer.
package fifo_stream_reader_pkg;

   localparam int unsigned DefaultDataW = 8;

   // Bits needed to count 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to index depth entries, never less than one.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/stream_reg_buffer.sv
// Circular register buffer with push/pop/count and a register-sourced head.
// Usable as a generic skid buffer; any depth, including non-powers of two.
module stream_reg_buffer
   import fifo_stream_reader_pkg::*;
#(
   parameter type         T     = logic [DefaultDataW-1:0],
   parameter int unsigned Depth = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  T                           push_data_i,
   input  logic                       pop_i,
   output logic                       valid_o,
   output T                           head_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);

   localparam int unsigned CntW = cnt_width(Depth);
   localparam int unsigned PtrW = ptr_width(Depth);

   T                mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_pop;

   function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Pointer and count update; a pop on an empty buffer is ignored.
   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      wr_ptr_d = push_i ? ptr_next(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_next(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Upstream credit accounting must never push into a full buffer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push_i && (count_q == CntW'(Depth))));
      end
   end

   assign valid_o = (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync FIFO into a valid/ready stream: credit-gated read issue, read-latency
// tracking, and a registered output buffer with no combinational path from out_ready.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter type         T           = logic [DefaultDataW-1:0],
   parameter int unsigned ReadLatency = 1,
   parameter int unsigned SkidDepth   = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           fifo_empty,
   output logic                           fifo_re,
   input  T                               fifo_r_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output T                               out_data,
   output logic [$clog2(SkidDepth+1)-1:0] occupancy
);

   localparam int unsigned CntW = cnt_width(SkidDepth);
   localparam int unsigned SumW = CntW + 1;

   logic fifo_re_c;
   logic inflight;
   logic capture;
   T     capture_data;
   logic pop;

   generate
      if (ReadLatency == 0) begin : g_lat0
         // Data arrives in the issue cycle, so nothing is ever in flight.
         assign inflight     = 1'b0;
         assign capture      = fifo_re_c;
         assign capture_data = fifo_r_data;
      end else begin : g_lat1
         logic inflight_q, inflight_d;

         always_comb begin
            inflight_d = fifo_re_c;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               inflight_q <= 1'b0;
            end else begin
               inflight_q <= inflight_d;
            end
         end

         assign inflight     = inflight_q;
         assign capture      = inflight_q;
         assign capture_data = fifo_r_data;
      end
   endgenerate

   // Credit uses the registered count only, so a pop this cycle is not credited yet.
   always_comb begin
      fifo_re_c = !rst && !fifo_empty &&
                  ((SumW'(occupancy) + SumW'(inflight)) < SumW'(SkidDepth));
      pop       = out_valid && out_ready;
   end

   assign fifo_re = fifo_re_c;

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(fifo_re_c && fifo_empty));
      end
   end

   stream_reg_buffer #(
      .T     (T),
      .Depth (SkidDepth)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (capture),
      .push_data_i (capture_data),
      .pop_i       (pop),
      .valid_o     (out_valid),
      .head_o      (out_data),
      .count_o     (occupancy)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: bench-side sync FIFO (1-cycle read latency) plus an
// in-order scoreboard of every word written into that FIFO.
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_empty;
   logic       fifo_re;
   logic [7:0] fifo_r_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem[$];
   logic [7:0] exp_q[$];

   logic       obs_re, obs_valid, obs_xfer;
   logic [7:0] obs_data;
   logic [1:0] obs_occ;

   always #5 clk = ~clk;

   fifo_stream_reader #(
      .T           (logic [7:0]),
      .ReadLatency (1),
      .SkidDepth   (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_re     (fifo_re),
      .fifo_r_data (fifo_r_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .occupancy   (occupancy)
   );

   task automatic fifo_write(input logic [7:0] w);
      mem.push_back(w);
      exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic fifo_flush();
      mem.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
   endtask

   // One clock cycle: entered and left at negedge; observes, scores, then models the FIFO.
   task automatic cycle();
      logic [7:0] want;
      #1;
      obs_re    = fifo_re;
      obs_valid = out_valid;
      obs_data  = out_data;
      obs_occ   = occupancy;
      obs_xfer  = !rst && obs_valid && out_ready;
      n_checks++;
      if (obs_re && fifo_empty) begin
         n_fail++;
         $display("FAIL re_while_empty: fifo_re=%b with fifo_empty=%b, required no read", obs_re, fifo_empty);
      end
      n_checks++;
      if (obs_valid !== (obs_occ != 2'd0)) begin
         n_fail++;
         $display("FAIL valid_vs_occ: out_valid=%b occupancy=%0d, required out_valid=(occupancy!=0)", obs_valid, obs_occ);
      end
      if (obs_xfer) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_word: got %h, required no transfer", obs_data);
         end else begin
            want = exp_q.pop_front();
            if (obs_data !== want) begin
               n_fail++;
               $display("FAIL order: out_data=%h, required %h", obs_data, want);
            end
         end
      end
      @(posedge clk);
      #1;
      if (obs_re && mem.size() > 0) fifo_r_data = mem.pop_front();
      fifo_empty = (mem.size() == 0);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() > 0 || out_valid); i++) cycle();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d words undelivered, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fifo_write(8'h11);
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (obs_re !== 1'b0 || obs_valid !== 1'b0 || obs_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: re=%b valid=%b occ=%0d, required 0/0/0", obs_re, obs_valid, obs_occ);
         end
      end
      fifo_flush();
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_single();
      logic       exp_re[4]    = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic       exp_valid[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [1:0] exp_occ[4]   = '{2'd0, 2'd0, 2'd1, 2'd0};
      out_ready = 1'b1;
      fifo_write(8'hA5);
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_checks++;
         if (obs_re !== exp_re[i] || obs_valid !== exp_valid[i] || obs_occ !== exp_occ[i]) begin
            n_fail++;
            $display("FAIL single_c%0d: re=%b valid=%b occ=%0d, required %b/%b/%0d",
                     i, obs_re, obs_valid, obs_occ, exp_re[i], exp_valid[i], exp_occ[i]);
         end
         if (exp_valid[i]) begin
            n_checks++;
            if (obs_data !== 8'hA5) begin
               n_fail++;
               $display("FAIL single_data: got %h, required a5", obs_data);
            end
         end
      end
   endtask

   task automatic test_stream();
      int first = -1;
      int nx    = 0;
      int gaps  = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) fifo_write(8'(i));
      for (int c = 0; c < 40; c++) begin
         cycle();
         if (obs_xfer) begin
            if (first < 0) first = c;
            nx++;
         end else if (first >= 0 && nx < 16) begin
            gaps++;
         end
      end
      n_checks++;
      if (nx != 16) begin
         n_fail++;
         $display("FAIL stream_count: %0d transfers, required 16", nx);
      end
      n_checks++;
      if (first != 2) begin
         n_fail++;
         $display("FAIL stream_latency: first transfer in cycle %0d, required 2", first);
      end
      n_checks++;
      if (gaps != 0) begin
         n_fail++;
         $display("FAIL stream_bubbles: %0d bubbles, required 0", gaps);
      end
   endtask

   task automatic test_backpressure();
      int nre = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) fifo_write(8'(i));
      for (int c = 0; c < 6; c++) begin
         cycle();
         if (obs_re) nre++;
         if (obs_valid) begin
            n_checks++;
            if (obs_data !== 8'h00) begin
               n_fail++;
               $display("FAIL bp_stable: out_data=%h while stalled, required 00", obs_data);
            end
         end
      end
      n_checks++;
      if (nre != 3) begin
         n_fail++;
         $display("FAIL bp_reads: %0d fifo_re pulses, required 3", nre);
      end
      n_checks++;
      if (obs_occ !== 2'd3 || obs_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_full: occ=%0d valid=%b, required 3/1", obs_occ, obs_valid);
      end
      drain("bp");
   endtask

   task automatic test_random();
      logic       pv = 1'b0;
      logic       pr = 1'b0;
      logic [7:0] pd = '0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) fifo_write(8'($urandom));
         end
         out_ready = 1'($urandom_range(0, 1));
         cycle();
         if (pv && !pr) begin
            n_checks++;
            if (obs_valid !== 1'b1 || obs_data !== pd) begin
               n_fail++;
               $display("FAIL stall_hold: valid=%b data=%h, required 1/%h", obs_valid, obs_data, pd);
            end
         end
         pv = obs_valid;
         pr = out_ready;
         pd = obs_data;
      end
      drain("rand");
   endtask

   task automatic test_reset_inflight();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) fifo_write(8'(8'h40 + i));
      cycle();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      n_checks++;
      if (obs_occ !== 2'd2) begin
         n_fail++;
         $display("FAIL rst_pre: occupancy=%0d before reset, required 2", obs_occ);
      end
      rst = 1'b0;
      fifo_flush();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cycle();
         n_checks++;
         if (obs_valid !== 1'b0 || obs_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_flush: valid=%b occ=%0d data=%h, required 0/0", obs_valid, obs_occ, obs_data);
         end
      end
      fifo_write(8'h3C);
      drain("post_rst");
   endtask

   initial begin
      rst         = 1'b1;
      fifo_empty  = 1'b1;
      out_ready   = 1'b0;
      fifo_r_data = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_random();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
